draw_rect_img: RTL

// - Overlays a 48x64 bitmap onto the VGA pixel stream at a runtime position (xpos, ypos).
// - Sits between the background/timing stage and the VGA output.
// - Drives pixel_addr into the image ROM (1-cycle registered read) and consumes its rgb_pixel.
// - Delays all timing signals so sync/blank stay aligned with the merged colour.

---
 rtl/draw_rect_img.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/draw_rect_img.sv
// draw_rect_img: overlays an IMG_W x IMG_H bitmap onto the VGA pixel stream at a
// per-frame latched position (xpos, ypos). It drives a 1-cycle registered image ROM
// through pixel_addr and merges the returned rgb_pixel with the background colour.
// All timing signals are delayed 3 clocks so that sync/blank stay aligned with rgb_out.
//
// Optional feature macro: DRAW_TRANSPARENT_KEY_EN
//   defined     -> ROM pixels equal to KEY_RGB are transparent (background shows)
//   not defined -> every in-rectangle pixel shows the ROM colour, KEY_RGB unused

module draw_rect_img #(
  parameter int          IMG_W   = 48,
  parameter int          IMG_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Bitmap extents widened to 12 bits so that "left edge + size" never wraps.
  localparam logic [11:0] IMG_W12 = 12'(IMG_W);
  localparam logic [11:0] IMG_H12 = 12'(IMG_H);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when pos lies in [lo, lo+size). Evaluated 12 bits wide: an image that
  // runs past the end of the counter range is clipped instead of wrapping to 0.
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] lo,
                                   input logic [11:0] size);
    logic [11:0] pos_ext;
    logic [11:0] lo_ext;
    logic [11:0] hi_ext;
    pos_ext = {1'b0, pos};
    lo_ext  = {1'b0, lo};
    hi_ext  = lo_ext + size;
    return (pos_ext >= lo_ext) && (pos_ext < hi_ext);
  endfunction

  // Low 6 bits of (a - b); only the low bits of each operand affect the result,
  // so the subtraction is done on the 6-bit slices directly.
  function automatic logic [5:0] offset6(input logic [5:0] a,
                                         input logic [5:0] b);
    return a - b;
  endfunction

  // ---------------------------------------------------------------------------
  // Latched image position
  // ---------------------------------------------------------------------------
  logic [10:0] r_xpos_l;
  logic [10:0] r_ypos_l;
  logic        w_frame_start;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  // Capture the requested position once per frame so the image never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos_l <= 11'd0;
      r_ypos_l <= 11'd0;
    end else if (w_frame_start) begin
      r_xpos_l <= xpos;
      r_ypos_l <= ypos;
    end else begin
      r_xpos_l <= r_xpos_l;
      r_ypos_l <= r_ypos_l;
    end
  end

  // ---------------------------------------------------------------------------
  // Rectangle hit test and ROM address (combinational, stage 1 inputs)
  // ---------------------------------------------------------------------------
  logic        w_in_rect;
  logic [5:0]  w_addr_x;
  logic [5:0]  w_addr_y;
  logic [11:0] w_addr;

  // Decide whether the incoming pixel falls inside the visible bitmap area.
  always_comb begin
    w_in_rect = 1'b0;
    w_addr_x  = offset6(hcount_in[5:0], r_xpos_l[5:0]);
    w_addr_y  = offset6(vcount_in[5:0], r_ypos_l[5:0]);
    w_addr    = 12'h000;
    if (!hblnk_in && !vblnk_in) begin
      w_in_rect = in_span(hcount_in, r_xpos_l, IMG_W12) &&
                  in_span(vcount_in, r_ypos_l, IMG_H12);
    end else begin
      w_in_rect = 1'b0;
    end
    if (w_in_rect) begin
      w_addr = {w_addr_y, w_addr_x};
    end else begin
      w_addr = 12'h000;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: timing delay, hit flag, background colour, ROM address
  // ---------------------------------------------------------------------------
  logic [10:0] r_hcount_d1;
  logic [10:0] r_vcount_d1;
  logic        r_hsync_d1;
  logic        r_vsync_d1;
  logic        r_hblnk_d1;
  logic        r_vblnk_d1;
  logic        r_in_rect_d1;
  logic [11:0] r_rgb_d1;
  logic [11:0] r_pixel_addr;

  // First pipeline stage; the address goes straight to the ROM from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount_d1  <= 11'd0;
      r_vcount_d1  <= 11'd0;
      r_hsync_d1   <= 1'b0;
      r_vsync_d1   <= 1'b0;
      r_hblnk_d1   <= 1'b0;
      r_vblnk_d1   <= 1'b0;
      r_in_rect_d1 <= 1'b0;
      r_rgb_d1     <= 12'h000;
      r_pixel_addr <= 12'h000;
    end else begin
      r_hcount_d1  <= hcount_in;
      r_vcount_d1  <= vcount_in;
      r_hsync_d1   <= hsync_in;
      r_vsync_d1   <= vsync_in;
      r_hblnk_d1   <= hblnk_in;
      r_vblnk_d1   <= vblnk_in;
      r_in_rect_d1 <= w_in_rect;
      r_rgb_d1     <= rgb_in;
      r_pixel_addr <= w_addr;
    end
  end

  assign pixel_addr = r_pixel_addr;

  // ---------------------------------------------------------------------------
  // Stage 2: wait for the ROM's registered read
  // ---------------------------------------------------------------------------
  logic [10:0] r_hcount_d2;
  logic [10:0] r_vcount_d2;
  logic        r_hsync_d2;
  logic        r_vsync_d2;
  logic        r_hblnk_d2;
  logic        r_vblnk_d2;
  logic        r_in_rect_d2;
  logic [11:0] r_rgb_d2;

  // Second stage keeps everything in step with the ROM data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount_d2  <= 11'd0;
      r_vcount_d2  <= 11'd0;
      r_hsync_d2   <= 1'b0;
      r_vsync_d2   <= 1'b0;
      r_hblnk_d2   <= 1'b0;
      r_vblnk_d2   <= 1'b0;
      r_in_rect_d2 <= 1'b0;
      r_rgb_d2     <= 12'h000;
    end else begin
      r_hcount_d2  <= r_hcount_d1;
      r_vcount_d2  <= r_vcount_d1;
      r_hsync_d2   <= r_hsync_d1;
      r_vsync_d2   <= r_vsync_d1;
      r_hblnk_d2   <= r_hblnk_d1;
      r_vblnk_d2   <= r_vblnk_d1;
      r_in_rect_d2 <= r_in_rect_d1;
      r_rgb_d2     <= r_rgb_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Colour merge
  // ---------------------------------------------------------------------------
  logic        w_use_pixel;
  logic [11:0] w_rgb_merged;

`ifdef DRAW_TRANSPARENT_KEY_EN
  // Key-coloured ROM pixels let the background through.
  assign w_use_pixel = r_in_rect_d2 && (rgb_pixel != KEY_RGB);
`else
  // Opaque build: the key colour is drawn like any other ROM colour.
  logic w_unused_key;
  assign w_unused_key = ^KEY_RGB;
  assign w_use_pixel  = r_in_rect_d2;
`endif

  // Choose between bitmap and background for the pixel leaving stage 2.
  always_comb begin
    w_rgb_merged = r_rgb_d2;
    if (w_use_pixel) begin
      w_rgb_merged = rgb_pixel;
    end else begin
      w_rgb_merged = r_rgb_d2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: registered outputs
  // ---------------------------------------------------------------------------
  logic [10:0] r_hcount_out;
  logic [10:0] r_vcount_out;
  logic        r_hsync_out;
  logic        r_vsync_out;
  logic        r_hblnk_out;
  logic        r_vblnk_out;
  logic [11:0] r_rgb_out;

  // Output stage; every output is exactly three clocks behind its input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount_out <= 11'd0;
      r_vcount_out <= 11'd0;
      r_hsync_out  <= 1'b0;
      r_vsync_out  <= 1'b0;
      r_hblnk_out  <= 1'b0;
      r_vblnk_out  <= 1'b0;
      r_rgb_out    <= 12'h000;
    end else begin
      r_hcount_out <= r_hcount_d2;
      r_vcount_out <= r_vcount_d2;
      r_hsync_out  <= r_hsync_d2;
      r_vsync_out  <= r_vsync_d2;
      r_hblnk_out  <= r_hblnk_d2;
      r_vblnk_out  <= r_vblnk_d2;
      r_rgb_out    <= w_rgb_merged;
    end
  end

  assign hcount_out = r_hcount_out;
  assign vcount_out = r_vcount_out;
  assign hsync_out  = r_hsync_out;
  assign vsync_out  = r_vsync_out;
  assign hblnk_out  = r_hblnk_out;
  assign vblnk_out  = r_vblnk_out;
  assign rgb_out    = r_rgb_out;

endmodule
